// File: rtl/data_mem_store_buffer_pkg.sv
// Shared constants and types for the data-memory store buffer (dmem_pkg).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dmem_pkg;

  localparam int DATA_W    = 4;
  localparam int ADDR_W    = 4;
  localparam int DEPTH     = 4;
  localparam int PTR_W     = $clog2(DEPTH);
  localparam int CNT_W     = PTR_W + 1;
  localparam int MEM_DEPTH = 1 << ADDR_W;

  // One posted store waiting to retire into the array.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } store_entry_t;

endpackage

// File: rtl/data_mem_store_buffer_if.sv
// CPU <-> data-memory request/response bundle; master is the CPU side, slave the memory side.
// Latency: n/a (wiring only).
// Backpressure: slave raises stall; master holds every request field stable and retries.
interface data_mem_store_buffer_if;
  import dmem_pkg::*;

  logic              MemWrite;
  logic              MemRead;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] writeData;
  logic [DATA_W-1:0] readData;
  logic              readValid;
  logic              stall;
  logic [CNT_W-1:0]  bufCount;
  logic              bufEmpty;

  modport master (
    output MemWrite, MemRead, address, writeData,
    input  readData, readValid, stall, bufCount, bufEmpty
  );

  modport slave (
    input  MemWrite, MemRead, address, writeData,
    output readData, readValid, stall, bufCount, bufEmpty
  );

endinterface

// File: rtl/data_mem_store_buffer_store_fifo.sv
// Circular store buffer with per-entry address match and youngest-match selector (selector only with DMEM_FWD_EN).
// Latency: push visible to lookups the cycle after it is accepted; head is combinational.
// Backpressure: push ignored when full unless a pop happens the same cycle; pop ignored when empty.
module store_fifo
  import dmem_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              push,
  input  store_entry_t      pushEntry,
  input  logic              pop,
  input  logic [ADDR_W-1:0] lookupAddr,
  output store_entry_t      headEntry,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full,
  output logic [DEPTH-1:0]  matchVec,
  output logic              fwdHit,
  output logic [DATA_W-1:0] fwdData
);

  store_entry_t     entries [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [CNT_W-1:0] countNext;
  logic             emptyQ;
  logic             doPush;
  logic             doPop;

  assign full      = (count == CNT_W'(DEPTH));
  assign empty     = emptyQ;
  assign headEntry = entries[rdPtr];
  assign doPop     = pop && !emptyQ;
  // A full buffer can take a push only when the head leaves in the same cycle.
  assign doPush    = push && (!full || doPop);

  // Next occupancy from the accepted push/pop pair.
  always_comb begin
    countNext = count;
    if (doPush && !doPop) begin
      countNext = count + CNT_W'(1);
    end else if (doPop && !doPush) begin
      countNext = count - CNT_W'(1);
    end
  end

  // Per-entry match: entry is live if its distance from the read pointer is below count.
  always_comb begin
    logic [PTR_W-1:0] off;
    off      = '0;
    matchVec = '0;
    for (int j = 0; j < DEPTH; j++) begin
      off         = PTR_W'(j) - rdPtr;
      matchVec[j] = ({1'b0, off} < count) && (entries[j].addr == lookupAddr);
    end
  end

`ifdef DMEM_FWD_EN
  // Walk oldest to youngest so the last hit seen is the youngest matching store.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx     = '0;
    fwdHit  = 1'b0;
    fwdData = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rdPtr + PTR_W'(i);
      if (matchVec[idx]) begin
        fwdHit  = 1'b1;
        fwdData = entries[idx].data;
      end
    end
  end
`else
  assign fwdHit  = 1'b0;
  assign fwdData = '0;
`endif

  // Pointer, occupancy and entry storage; reset discards all buffered stores.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wrPtr  <= '0;
      rdPtr  <= '0;
      count  <= '0;
      emptyQ <= 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else begin
      if (doPush) begin
        entries[wrPtr] <= pushEntry;
        wrPtr          <= wrPtr + PTR_W'(1);
      end
      if (doPop) begin
        rdPtr <= rdPtr + PTR_W'(1);
      end
      count  <= countNext;
      emptyQ <= (countNext == '0);
    end
  end

endmodule

// File: rtl/data_mem_store_buffer.sv
// 16x4 data memory behind a 4-entry posted store buffer; DMEM_FWD_EN selects store-to-load forwarding.
// Latency: load data registered 1 cycle after acceptance; stores retire when the port is free of loads.
// Backpressure: stall is combinational; the CPU holds MemRead/MemWrite/address/writeData and retries.
module data_mem_store_buffer
  import dmem_pkg::*;
(
  input logic                     clock,
  input logic                     reset_n,
  data_mem_store_buffer_if.slave  bus
);

  logic [DATA_W-1:0] mem [MEM_DEPTH];
  store_entry_t      headEntry;
  store_entry_t      pushEntry;
  logic [CNT_W-1:0]  count;
  logic              empty;
  logic              full;
  logic [DEPTH-1:0]  matchVec;
  logic              fwdHit;
  logic [DATA_W-1:0] fwdData;
  logic              pairBlock;
  logic              loadHazard;
  logic              stallInt;
  logic              loadAcc;
  logic              storeAcc;
  logic              drain;
  logic [DATA_W-1:0] readDataQ;
  logic              readValidQ;

  assign pushEntry = '{addr: bus.address, data: bus.writeData};

  store_fifo uStoreFifo (
    .clock      (clock),
    .reset_n    (reset_n),
    .push       (storeAcc),
    .pushEntry  (pushEntry),
    .pop        (drain),
    .lookupAddr (bus.address),
    .headEntry  (headEntry),
    .count      (count),
    .empty      (empty),
    .full       (full),
    .matchVec   (matchVec),
    .fwdHit     (fwdHit),
    .fwdData    (fwdData)
  );

  // A load+store pair against a full buffer cannot fit: the load would own the port,
  // so nothing drains to make room. Both are refused; because the refused load does not
  // own the port, the head drains that cycle and the retried pair then fits.
  assign pairBlock = bus.MemRead && bus.MemWrite && full;

`ifdef DMEM_FWD_EN
  assign loadHazard = 1'b0;
`else
  // Without forwarding a load must wait until no buffered store targets its address.
  assign loadHazard = bus.MemRead && (|matchVec);
`endif

  assign stallInt = pairBlock || loadHazard;
  assign loadAcc  = bus.MemRead && !stallInt;
  assign storeAcc = bus.MemWrite && !stallInt;
  // Single-port array: an accepted load owns it, otherwise the oldest store retires.
  assign drain    = !empty && !loadAcc;

  // Memory array: cleared on reset, written only by the drain path.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (drain) begin
      mem[headEntry.addr] <= headEntry.data;
    end
  end

  // Load result register; buffered data (pre-enqueue view) overrides the array on a hit.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      readDataQ  <= '0;
      readValidQ <= 1'b0;
    end else begin
      readValidQ <= loadAcc;
      if (loadAcc) begin
        readDataQ <= fwdHit ? fwdData : mem[bus.address];
      end
    end
  end

  assign bus.readData  = readDataQ;
  assign bus.readValid = readValidQ;
  assign bus.stall     = stallInt;
  assign bus.bufCount  = count;
  assign bus.bufEmpty  = empty;

endmodule

// File: tb/tb_data_mem_store_buffer.sv
// Directed bench for data_mem_store_buffer with a load-data scoreboard; honours DMEM_FWD_EN.
// Latency: expects load data one cycle after the accepting edge.
// Backpressure: driver holds requests while stall is high, bounded by a cycle budget.
module tb_data_mem_store_buffer;
  import dmem_pkg::*;

  logic clock = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   failures = 0;
  int   st;
  logic [DATA_W-1:0] expQ [$];

  data_mem_store_buffer_if bus ();

  data_mem_store_buffer dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every readValid pulse must match the oldest outstanding load expectation.
  always @(negedge clock) begin
    if (reset_n === 1'b1 && bus.readValid === 1'b1) begin
      if (expQ.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_readValid: got pulse with readData=%0d, expected no pulse", bus.readData);
      end else begin
        chk("load_data", int'(bus.readData), int'(expQ.pop_front()));
      end
    end
  end

  // Drive one request at the falling edge, hold through stalls, release after the accepting edge.
  task automatic issue(input logic rd, input logic wr, input int a, input int d,
                       input int exp, output int stalls);
    stalls = 0;
    @(negedge clock);
    bus.MemRead   = rd;
    bus.MemWrite  = wr;
    bus.address   = ADDR_W'(a);
    bus.writeData = DATA_W'(d);
    #1;
    while (bus.stall && stalls < 20) begin
      stalls++;
      @(negedge clock);
      #1;
    end
    if (bus.stall) begin
      checks++;
      failures++;
      $display("FAIL issue_timeout: stall=1 after %0d cycles, expected 0", stalls);
    end else if (rd) begin
      expQ.push_back(DATA_W'(exp));
    end
    @(posedge clock);
    #1;
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    reset_n       = 1'b0;
    bus.MemRead   = 1'b0;
    bus.MemWrite  = 1'b0;
    bus.address   = '0;
    bus.writeData = '0;
    repeat (3) @(negedge clock);
    chk("rst_readData", int'(bus.readData), 0);
    chk("rst_readValid", int'(bus.readValid), 0);
    chk("rst_stall", int'(bus.stall), 0);
    chk("rst_bufCount", int'(bus.bufCount), 0);
    chk("rst_bufEmpty", int'(bus.bufEmpty), 1);
    reset_n = 1'b1;

    // Load from freshly reset memory.
    issue(1, 0, 3, 0, 0, st);
    idle(2);

    // Two stores with no loads: count 1, 1, then empty.
    issue(0, 1, 2, 5, 0, st);
    chk("cnt_after_st1", int'(bus.bufCount), 1);
    issue(0, 1, 3, 6, 0, st);
    chk("cnt_after_st2", int'(bus.bufCount), 1);
    idle(1);
    chk("cnt_drained", int'(bus.bufCount), 0);
    chk("empty_drained", int'(bus.bufEmpty), 1);
    issue(1, 0, 2, 0, 5, st);
    issue(1, 0, 3, 0, 6, st);
    idle(2);

    // Store then immediate load of the same address.
    issue(0, 1, 4, 9, 0, st);
    issue(1, 0, 4, 0, 9, st);
`ifdef DMEM_FWD_EN
    chk("raw_stall_cycles", st, 0);
`else
    chk("raw_stall_cycles", st, 1);
`endif
    idle(4);

    // Two stores to one address then a load: youngest wins.
    issue(0, 1, 7, 1, 0, st);
    issue(0, 1, 7, 2, 0, st);
    issue(1, 0, 7, 0, 2, st);
`ifdef DMEM_FWD_EN
    chk("youngest_stall_cycles", st, 0);
`else
    chk("youngest_stall_cycles", st, 1);
`endif
    idle(4);
    chk("empty_before_fill", int'(bus.bufEmpty), 1);

    // Fill the buffer with load+store pairs (loads keep the port, nothing drains).
    for (int i = 0; i < 4; i++) begin
      issue(1, 1, 8 + i, 10 + i, 0, st);
      chk("fill_no_stall", st, 0);
    end
    chk("fill_count", int'(bus.bufCount), 4);
    @(negedge clock);
    bus.MemRead   = 1'b1;
    bus.MemWrite  = 1'b1;
    bus.address   = ADDR_W'(12);
    bus.writeData = DATA_W'(14);
    #1;
    chk("full_pair_stall", int'(bus.stall), 1);
    issue(1, 1, 12, 14, 0, st);
    chk("full_retry_count", int'(bus.bufCount), 4);
    idle(6);
    chk("empty_after_fill", int'(bus.bufEmpty), 1);
    for (int i = 0; i < 5; i++) begin
      issue(1, 0, 8 + i, 0, 10 + i, st);
    end
    idle(2);

    // Simultaneous load+store: load sees the old value, later load the new one.
    issue(0, 1, 0, 3, 0, st);
    idle(3);
    issue(1, 1, 0, 8, 3, st);
    chk("pair_no_stall", st, 0);
    issue(1, 0, 0, 0, 8, st);
    idle(3);

    // Asynchronous reset while the buffer is draining.
    issue(1, 0, 8, 0, 10, st);
    issue(0, 1, 5, 7, 0, st);
    issue(0, 1, 6, 7, 0, st);
    chk("pre_reset_count", int'(bus.bufCount), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_readData", int'(bus.readData), 0);
    chk("midrst_readValid", int'(bus.readValid), 0);
    chk("midrst_stall", int'(bus.stall), 0);
    chk("midrst_bufCount", int'(bus.bufCount), 0);
    chk("midrst_bufEmpty", int'(bus.bufEmpty), 1);
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    issue(1, 0, 5, 0, 0, st);
    issue(1, 0, 8, 0, 0, st);
    idle(3);
    chk("scoreboard_empty", expQ.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
